// File: rtl/ovl_fifo_index_checker.sv
// FIFO occupancy checker: tracks the index from push/pop strobes and flags overflow,
// underflow, illegal simultaneous push/pop and X/Z inputs. Define OVL_FIFO_INDEX_COVER_EN for cover events.
module ovl_fifo_index_checker #(
  parameter int DEPTH                 = 1,
  parameter int PUSH_WIDTH            = 1,
  parameter int POP_WIDTH             = 1,
  parameter int SIMULTANEOUS_PUSH_POP = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PUSH_WIDTH-1:0] push,
  input  logic [POP_WIDTH-1:0]  pop,
  output logic [2:0]            fire,
  output logic [7:0]            count
);

  // Wide enough for DEPTH (<= 255) plus the largest push or pop, so cnt + push never wraps.
  localparam int SW = ((PUSH_WIDTH > POP_WIDTH) ? PUSH_WIDTH : POP_WIDTH) + 9;
  localparam logic [7:0]    DEPTH_C = 8'(DEPTH);
  localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);

  logic [7:0]    cnt;
  logic [7:0]    next_cnt;
  logic [SW-1:0] sum;
  logic [SW-1:0] net;
  logic          overflow;
  logic          underflow;
  logic          simult;
  logic          violation;
  logic          x_seen;
  logic          cover_hit;

  always_comb begin
    sum       = SW'(cnt) + SW'(push);
    underflow = SW'(pop) > sum;
    net       = sum - SW'(pop);
    overflow  = (push != '0) && !underflow && (net > DEPTH_W);
    simult    = (SIMULTANEOUS_PUSH_POP == 0) && (push != '0) && (pop != '0);
    violation = overflow | underflow | simult;
    x_seen    = $isunknown({push, pop});

    if (underflow)           next_cnt = '0;
    else if (net > DEPTH_W)  next_cnt = DEPTH_C;
    else                     next_cnt = net[7:0];
  end

`ifdef OVL_FIFO_INDEX_COVER_EN
  assign cover_hit = ((next_cnt == DEPTH_C) && (cnt != DEPTH_C)) ||
                     ((cnt != '0) && (next_cnt == '0));
`else
  assign cover_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      fire <= '0;
    end else if (!enable) begin
      fire <= '0;
    end else if (x_seen) begin
      // An unknown strobe cannot be trusted to move the index, so it only raises the X/Z bit.
      fire <= 3'b010;
    end else begin
      cnt  <= next_cnt;
      fire <= {cover_hit, 1'b0, violation};
    end
  end

  assign count = cnt;

endmodule

// File: tb/tb_ovl_fifo_index_checker.sv
// Bench for ovl_fifo_index_checker: a DEPTH=1 instance and a DEPTH=4, 2-bit, no-simultaneous
// instance driven side by side from a vector table plus hand sequences, checked via a scoreboard.
module tb_ovl_fifo_index_checker;

`ifdef OVL_FIFO_INDEX_COVER_EN
  localparam bit COVER = 1'b1;
`else
  localparam bit COVER = 1'b0;
`endif

  localparam int DEPTH_A = 1;
  localparam int DEPTH_B = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       push_a, pop_a;
  logic [1:0] push_b, pop_b;
  logic [2:0] fire_a, fire_b;
  logic [7:0] count_a, count_b;

  always #5 clk = ~clk;

  ovl_fifo_index_checker #(
    .DEPTH(DEPTH_A), .PUSH_WIDTH(1), .POP_WIDTH(1), .SIMULTANEOUS_PUSH_POP(1)
  ) dut_a (
    .clock(clk), .reset(rst_n), .enable(enable),
    .push(push_a), .pop(pop_a), .fire(fire_a), .count(count_a)
  );

  ovl_fifo_index_checker #(
    .DEPTH(DEPTH_B), .PUSH_WIDTH(2), .POP_WIDTH(2), .SIMULTANEOUS_PUSH_POP(0)
  ) dut_b (
    .clock(clk), .reset(rst_n), .enable(enable),
    .push(push_b), .pop(pop_b), .fire(fire_b), .count(count_b)
  );

  typedef struct {
    string      name;
    bit         en;
    logic       pa, qa;
    logic [1:0] pb, qb;
    bit         f0a;
    int         ca;
    bit         f0b;
    int         cb;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] fa;
    logic [7:0] ca;
    logic [2:0] fb;
    logic [7:0] cb;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_cnt_a  = 0;
  int   m_cnt_b  = 0;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  function automatic bit cov(input int depth, input int prev, input int nxt);
    return COVER && (((nxt == depth) && (prev != depth)) || ((prev != 0) && (nxt == 0)));
  endfunction

  // Reference behaviour for one sampled edge; updates cnt and returns the expected fire bits.
  function automatic void model(input int depth, input int sim, input bit en, input bit xf,
                                input int pu, input int po, inout int cnt, output logic [2:0] f);
    int net, nxt;
    bit uf, of, sv;
    f = 3'b000;
    if (!en) return;
    if (xf) begin
      f = 3'b010;
      return;
    end
    net = cnt + pu - po;
    uf  = po > cnt + pu;
    of  = (pu > 0) && (net > depth);
    sv  = (sim == 0) && (pu > 0) && (po > 0);
    nxt = uf ? 0 : ((net > depth) ? depth : net);
    f   = {cov(depth, cnt, nxt), 1'b0, uf | of | sv};
    cnt = nxt;
  endfunction

  // Drive at the falling edge, queue the expectation, compare after the following rising edge.
  task automatic apply(input string name, input bit en, input logic pa, input logic qa,
                       input logic [1:0] pb, input logic [1:0] qb,
                       input logic [2:0] efa, input int eca, input logic [2:0] efb, input int ecb);
    exp_t e;
    enable = en;
    push_a = pa;
    pop_a  = qa;
    push_b = pb;
    pop_b  = qb;
    sb.push_back('{name, efa, 8'(eca), efb, 8'(ecb)});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({e.name, " fire_a"},  {5'b0, fire_a}, {5'b0, e.fa});
    check({e.name, " count_a"}, count_a, e.ca);
    check({e.name, " fire_b"},  {5'b0, fire_b}, {5'b0, e.fb});
    check({e.name, " count_b"}, count_b, e.cb);
  endtask

  // Hand sequence step: expectations come from the reference model.
  task automatic step(input string name, input bit en, input logic pa, input logic qa,
                      input logic [1:0] pb, input logic [1:0] qb);
    logic [2:0] fa, fb;
    model(DEPTH_A, 1, en, $isunknown({pa, qa}), int'(pa), int'(qa), m_cnt_a, fa);
    model(DEPTH_B, 0, en, $isunknown({pb, qb}), int'(pb), int'(qb), m_cnt_b, fb);
    apply(name, en, pa, qa, pb, qb, fa, m_cnt_a, fb, m_cnt_b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vec[10];
    int   pa_prev, pb_prev;

    vec[0] = '{"push_to_full",      1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1, 1'b0, 2};
    vec[1] = '{"overflow",          1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 1, 1'b1, 4};
    vec[2] = '{"net_out_full",      1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1, 1'b1, 4};
    vec[3] = '{"drain",             1'b1, 1'b0, 1'b1, 2'd0, 2'd3, 1'b0, 0, 1'b0, 1};
    vec[4] = '{"underflow",         1'b1, 1'b0, 1'b1, 2'd0, 2'd2, 1'b1, 0, 1'b1, 0};
    vec[5] = '{"simult_empty",      1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 0, 1'b1, 0};
    vec[6] = '{"refill",            1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1, 1'b0, 3};
    vec[7] = '{"disabled_overflow", 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1, 1'b0, 3};
    vec[8] = '{"multi_violation",   1'b1, 1'b0, 1'b0, 2'd3, 2'd1, 1'b0, 1, 1'b1, 4};
    vec[9] = '{"partial_pop",       1'b1, 1'b1 ^ 1'b1, 1'b1, 2'd0, 2'd3, 1'b0, 0, 1'b0, 1};

    rst_n  = 1'b0;
    enable = 1'b1;
    push_a = 1'b1;
    pop_a  = 1'b0;
    push_b = 2'd3;
    pop_b  = 2'd0;

    // Reset held for 5 clocks with active strobes: outputs must stay cleared.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset fire_a",  {5'b0, fire_a}, 8'd0);
      check("reset count_a", count_a, 8'd0);
      check("reset fire_b",  {5'b0, fire_b}, 8'd0);
      check("reset count_b", count_b, 8'd0);
    end
    rst_n  = 1'b1;
    push_a = 1'b0;
    push_b = 2'd0;
    for (int i = 0; i < 5; i++) step("post_reset_idle", 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);

    pa_prev = 0;
    pb_prev = 0;
    for (int i = 0; i < 10; i++) begin
      logic [2:0] efa, efb;
      efa = {vec[i].en && cov(DEPTH_A, pa_prev, vec[i].ca), 1'b0, vec[i].f0a};
      efb = {vec[i].en && cov(DEPTH_B, pb_prev, vec[i].cb), 1'b0, vec[i].f0b};
      apply(vec[i].name, vec[i].en, vec[i].pa, vec[i].qa, vec[i].pb, vec[i].qb,
            efa, vec[i].ca, efb, vec[i].cb);
      pa_prev = vec[i].ca;
      pb_prev = vec[i].cb;
    end
    m_cnt_a = pa_prev;
    m_cnt_b = pb_prev;

    // Unknown strobes: ignored when disabled, flagged on fire[1] when enabled.
    step("fill_a",       1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    step("x_disabled",   1'b0, 1'bx, 1'b0, 2'bxx, 2'd0);
    step("x_enabled",    1'b1, 1'bx, 1'b0, 2'bxx, 2'd0);
    step("after_x_idle", 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);

    // Reset in the middle of a fire pulse clears outputs immediately.
    step("fill_b",        1'b1, 1'b0, 1'b0, 2'd2, 2'd0);
    step("overflow_pre",  1'b1, 1'b1, 1'b0, 2'd3, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst fire_a",  {5'b0, fire_a}, 8'd0);
    check("async_rst count_a", count_a, 8'd0);
    check("async_rst fire_b",  {5'b0, fire_b}, 8'd0);
    check("async_rst count_b", count_b, 8'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    m_cnt_a = 0;
    m_cnt_b = 0;
    step("post_mid_reset", 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    step("push_after_rst", 1'b1, 1'b1, 1'b0, 2'd1, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
